sdrc_wb_arbiter: RTL and testbench
==================================

# sdrc_wb_arbiter

Two-master Wishbone arbiter and sequencer in front of the SDRAM controller's single Wishbone slave port. It shares the controller between two requesters, such as a CPU port and a DMA port. Ownership is granted round-robin and held for the whole Wishbone cycle (`cyc` high). Address, data and strobes of the owner are routed to the controller, and `ack`/read data are routed back to the owner only.

## Interface
Parameters:
- `dw`, 32: Wishbone data width; `dw/8` byte selects.
- `APP_AW`, 26: application address width.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only when `WB_ARB_TIMEOUT_EN` is defined. Legal range 2..1023.

Ports:
- `sys_clk`, in, 1: single clock; all logic on its rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`, in, 1 each: master 0 Wishbone controls.
- `m0_adr_i`, in, APP_AW: master 0 address.
- `m0_sel_i`, in, dw/8: master 0 byte selects.
- `m0_dat_i`, in, dw: master 0 write data.
- `m0_dat_o`, out, dw: master 0 read data.
- `m0_ack_o`, out, 1: master 0 acknowledge.
- `m0_err_o`, out, 1: master 0 timeout error.
- `m1_*`, same set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, out, 1 each: controls to the SDRAM controller.
- `s_adr_o`, out, APP_AW: address to the SDRAM controller.
- `s_sel_o`, out, dw/8: byte selects to the SDRAM controller.
- `s_dat_o`, out, dw: write data to the SDRAM controller.
- `s_dat_i`, in, dw: read data from the SDRAM controller.
- `s_ack_i`, in, 1: acknowledge from the SDRAM controller.
- `gnt_o`, out, 2: one-hot owner; `00` when idle.

## Operation
State machine states: IDLE, OWN, DRAIN.
- IDLE:
  - `gnt_o`=00; `s_cyc_o`=`s_stb_o`=0.
  - If any `mX_cyc_i` is high, register a grant and go to OWN.
  - Single requester: that requester wins.
  - Both requesting: the master not in `last_gnt` wins.
- OWN:
  - `s_cyc_o`=1.
  - `s_stb_o`, `s_we_o`, `s_adr_o`, `s_sel_o`, `s_dat_o` follow the owner combinationally.
  - `s_ack_i` and `s_dat_i` are routed to the owner's `ack_o`/`dat_o`.
  - The non-owner sees `ack_o`=0, `err_o`=0 and `dat_o`=0.
  - When the owner's `cyc_i` is sampled low: set `last_gnt` to the owner, go to IDLE.
- DRAIN (timeout build only):
  - `s_cyc_o`=`s_stb_o`=0; owner's `ack_o`=0.
  - Stay until the owner's `cyc_i` is low, then update `last_gnt` and go to IDLE.
- `s_ack_i` while in IDLE or DRAIN is ignored and never forwarded.
- No preemption: a master holding `cyc` keeps the controller indefinitely, unless the watchdog fires.

## Timing
- Reset values (`resetn` low at a clock edge):
  - State IDLE; `gnt_o`=00; `last_gnt`=master 1, so master 0 wins the first tie.
  - All `s_*` outputs, all `mX_ack_o`/`mX_err_o`/`mX_dat_o` and the watchdog counter are 0.
- Reset mid-transaction aborts immediately; nothing is forwarded afterwards.
- Grant latency: `cyc` first high in cycle N gives `gnt_o` and `s_cyc_o` high in N+1, and the owner's `stb` is forwarded from N+1.
- Ack path is combinational, so zero added latency per beat. Back-to-back acks pass at one per cycle.
- Release:
  - Owner `cyc` sampled low in cycle N gives IDLE in N+1.
  - A pending requester is granted in N+2, so there is exactly one idle bubble between owners.
- Simultaneous: both `cyc` rise in the same cycle → grant goes to the master opposite `last_gnt`.
- Fairness: with both masters continuously re-requesting, grants alternate strictly.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` counts cycles in OWN with `s_stb_o`=1 and `s_ack_i`=0. It clears on `s_ack_i` and on leaving OWN.
  - When the count reaches `TIMEOUT`, in that same cycle:
    - the owner's `err_o` pulses for one cycle;
    - `s_cyc_o`/`s_stb_o` drop in the next cycle, and the state moves to DRAIN.
- Not defined:
  - No counter and no DRAIN state; `mX_err_o` are tied to 0.
  - `TIMEOUT` is ignored.

## Test plan
- Reset, then master 0 single write (adr=0x0000100, dat=0xA5A5_5A5A, sel=0xF), slave acks on its 3rd cycle → `gnt_o`=01 one cycle after `cyc`; `m0_ack_o` in the same cycle as `s_ack_i`; `m1_ack_o`=0 throughout.
- Both masters raise `cyc` in the same cycle after reset → master 0 is granted first. Master 1 is granted exactly 2 cycles after master 0 drops `cyc`. A further tie is then won by master 0.
- Master 1 does an 8-beat read burst with acks every cycle, data 0..7, while master 0 is waiting → `m1_dat_o` returns 0..7 with no gaps; master 0 is blocked until master 1's `cyc` falls.
- `resetn` asserted low during the 4th beat of an owned burst → the next cycle shows `gnt_o`=00, `s_cyc_o`=0 and all acks 0. The next tie after reset goes to master 0.
- Timeout build with `TIMEOUT`=16, slave never acks → `m0_err_o` pulses in the 16th stalled cycle; `s_cyc_o` is low in the next cycle; the block stays in DRAIN until `m0_cyc_i` falls, then grants master 1.
- Non-timeout build with the same stall for 2000 cycles → `m0_err_o` is never asserted and `s_cyc_o` stays high.

Source files
------------

// File: rtl/sdrc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_wb_arbiter
// Brief    : Two-master round-robin Wishbone arbiter in front of the SDRAM
//            controller slave port; ownership is held for the whole cycle.
//            Define WB_ARB_TIMEOUT_EN to add the stalled-strobe watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module sdrc_wb_arbiter #(
    parameter int dw      = 32,
    parameter int APP_AW  = 26,
    parameter int TIMEOUT = 64
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [APP_AW-1:0] m0_adr_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [dw-1:0]     m0_dat_i,
    output logic [dw-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [APP_AW-1:0] m1_adr_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [dw-1:0]     m1_dat_i,
    output logic [dw-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [APP_AW-1:0] s_adr_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [dw-1:0]     s_dat_o,
    input  logic [dw-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_timeout_range_bad
        $error("sdrc_wb_arbiter: TIMEOUT must be within 2..1023");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1
    } state_t;
`endif

    state_t     r_state;
    logic [1:0] r_gnt;
    logic       r_last_gnt;     // 0: master 0 owned last, 1: master 1

    logic w_own;
    logic w_own_cyc;
    logic w_pick_m1;
    logic w_wdt_hit;

    assign w_own     = (r_state == ST_OWN);
    assign w_own_cyc = r_gnt[1] ? m1_cyc_i : m0_cyc_i;
    assign w_pick_m1 = m1_cyc_i && (!m0_cyc_i || !r_last_gnt);

    // Owner's request path is combinational; everything is zeroed off-ownership
    assign s_cyc_o = w_own;
    assign s_stb_o = w_own && (r_gnt[1] ? m1_stb_i : m0_stb_i);
    assign s_we_o  = w_own && (r_gnt[1] ? m1_we_i  : m0_we_i);
    assign s_adr_o = !w_own ? '0 : (r_gnt[1] ? m1_adr_i : m0_adr_i);
    assign s_sel_o = !w_own ? '0 : (r_gnt[1] ? m1_sel_i : m0_sel_i);
    assign s_dat_o = !w_own ? '0 : (r_gnt[1] ? m1_dat_i : m0_dat_i);

    assign m0_ack_o = w_own && r_gnt[0] && s_ack_i;
    assign m1_ack_o = w_own && r_gnt[1] && s_ack_i;
    assign m0_dat_o = (w_own && r_gnt[0]) ? s_dat_i : '0;
    assign m1_dat_o = (w_own && r_gnt[1]) ? s_dat_i : '0;
    assign m0_err_o = w_wdt_hit && r_gnt[0];
    assign m1_err_o = w_wdt_hit && r_gnt[1];
    assign gnt_o    = r_gnt;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int                c_WDT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(TIMEOUT - 1);

    logic [c_WDT_W-1:0] r_wdt;

    // Hit fires in the stalled cycle that brings the count up to TIMEOUT
    assign w_wdt_hit = s_stb_o && !s_ack_i && (r_wdt == c_WDT_LAST);

    always_ff @(posedge sys_clk) begin
        if (!resetn || !w_own || s_ack_i) begin
            r_wdt <= '0;
        end else if (s_stb_o) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end
`else
    assign w_wdt_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 2'b00;
            r_last_gnt <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        r_gnt   <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!w_own_cyc) begin
                        r_last_gnt <= r_gnt[1];
                        r_gnt      <= 2'b00;
                        r_state    <= ST_IDLE;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (w_wdt_hit) begin
                        r_state <= ST_DRAIN;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_DRAIN: begin
                    if (!w_own_cyc) begin
                        r_last_gnt <= r_gnt[1];
                        r_gnt      <= 2'b00;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdrc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdrc_wb_arbiter
// Brief    : Self-checking bench for sdrc_wb_arbiter; forwarded acks are
//            matched against a scoreboard of expected owner/data/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdrc_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [25:0] m0_adr, m1_adr;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_wdat, m1_wdat;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [25:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat;
    logic        s_ack;
    logic [1:0]  gnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    typedef struct {
        logic        m;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sb_q[$];

    sdrc_wb_arbiter #(.dw(32), .APP_AW(26), .TIMEOUT(16)) u_dut (
        .sys_clk (clk),      .resetn  (resetn),
        .m0_cyc_i(m0_cyc),   .m0_stb_i(m0_stb),   .m0_we_i (m0_we),
        .m0_adr_i(m0_adr),   .m0_sel_i(m0_sel),   .m0_dat_i(m0_wdat),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc),   .m1_stb_i(m1_stb),   .m1_we_i (m1_we),
        .m1_adr_i(m1_adr),   .m1_sel_i(m1_sel),   .m1_dat_i(m1_wdat),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),  .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),  .s_sel_o (s_sel_o),  .s_dat_o (s_dat_o),
        .s_dat_i (s_dat),    .s_ack_i (s_ack),    .gnt_o   (gnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic slave_ack(input logic m, input logic [31:0] d);
        s_ack = 1'b1;
        s_dat = d;
        sb_q.push_back('{m: m, d: d, c: cyc_n});
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        s_ack  = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    // Every forwarded ack must match the oldest expected beat, same cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (m0_ack_o || m1_ack_o) begin
            if (sb_q.size() == 0) begin
                check("ack_unexp", {m1_ack_o, m0_ack_o}, 2'b00);
            end else begin
                e = sb_q.pop_front();
                check("ack_who", {m1_ack_o, m0_ack_o}, e.m ? 2'b10 : 2'b01);
                check("ack_dat", e.m ? m1_dat_o : m0_dat_o, e.d);
                check("ack_cyc", cyc_n, e.c);
                check("ack_other_dat", e.m ? m0_dat_o : m1_dat_o, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int err_seen;
        int cyc_low;
        resetn = 1'b0; s_ack = 1'b0; s_dat = '0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;

        // Reset state
        tick(); tick(); samp();
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_scyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("rst_sbus", {s_adr_o, s_sel_o, s_dat_o}, 0);
        check("rst_mout", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o}, 0);
        tick(); resetn = 1'b1;

        // Single write from master 0, slave acks in its 3rd cycle
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 26'h0000100;
        m0_wdat = 32'hA5A5_5A5A; m0_sel = 4'hF;
        samp();
        check("wr_gnt_n", {gnt_o, s_cyc_o}, 3'b000);
        tick(); samp();
        check("wr_gnt_n1", {gnt_o, s_cyc_o, s_stb_o, s_we_o}, 5'b01111);
        check("wr_adr", s_adr_o, 26'h0000100);
        check("wr_dat", s_dat_o, 32'hA5A5_5A5A);
        check("wr_sel", s_sel_o, 4'hF);
        tick(); samp();
        tick(); slave_ack(1'b0, 32'h0); samp();
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; samp();
        check("wr_hold", gnt_o, 2'b01);
        tick(); samp();
        check("wr_rel", {gnt_o, s_cyc_o}, 3'b000);

        // Slave ack while idle must not reach anyone
        tick(); s_ack = 1; s_dat = 32'hDEAD; samp();
        check("idle_ack", {m1_ack_o, m0_ack_o, m0_dat_o, m1_dat_o}, 0);

        // Tie after reset, release bubble, second tie
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 0;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 26'h0000200;
        samp();
        tick(); samp();
        check("tie0", gnt_o, 2'b01);
        check("tie0_route", {s_adr_o, s_we_o}, {26'h0000100, 1'b0});
        tick(); slave_ack(1'b0, 32'h1111_2222); samp();
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; samp();
        check("tie0_hold", gnt_o, 2'b01);
        tick(); samp();
        check("bubble", gnt_o, 2'b00);
        tick(); samp();
        check("m1_gnt", gnt_o, 2'b10);
        check("m1_route", {s_adr_o, s_we_o}, {26'h0000200, 1'b1});
        tick(); slave_ack(1'b1, 32'h3333_4444); samp();
        tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0; samp();
        tick(); samp();
        check("m1_rel", gnt_o, 2'b00);
        tick(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_we = 0; samp();
        tick(); samp();
        check("tie1", gnt_o, 2'b01);
        tick(); m0_cyc = 0; m0_stb = 0; samp();
        tick(); m0_cyc = 1; m0_stb = 1; samp();
        check("fair_bubble", gnt_o, 2'b00);
        tick(); samp();
        check("fair_m1", gnt_o, 2'b10);

        // Master 1 read burst of 8, master 0 waiting
        for (int i = 0; i < 8; i++) begin
            tick(); slave_ack(1'b1, 32'(i)); samp();
            check("burst_gnt", gnt_o, 2'b10);
        end
        tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0; samp();
        tick(); samp();
        check("burst_rel", gnt_o, 2'b00);
        tick(); samp();
        check("burst_m0", gnt_o, 2'b01);

        // Hand over to master 1 so last grant is master 0, then reset mid-burst
        tick(); m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1; samp();
        tick(); samp();
        tick(); samp();
        check("rb_gnt", gnt_o, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) resetn = 0;
            slave_ack(1'b1, 32'h100 + 32'(i));
            samp();
        end
        tick(); resetn = 1; m1_cyc = 0; m1_stb = 0; s_ack = 1; samp();
        check("rb_after", {gnt_o, s_cyc_o, m0_ack_o, m1_ack_o}, 5'b00000);
        tick(); s_ack = 0; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; samp();
        tick(); samp();
        check("rb_tie", gnt_o, 2'b01);

        // Stalled owner: the first owned cycle above is stall cycle 1
        check("stall1_err", m0_err_o, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 2; k <= 20; k++) begin
            tick(); samp();
            check("wdt_err", m0_err_o, (k == 16) ? 1'b1 : 1'b0);
            if (k >= 17) check("drain_cyc", {s_cyc_o, s_stb_o, gnt_o[1]}, 3'b000);
        end
`else
        err_seen = 0;
        cyc_low  = 0;
        for (int k = 2; k <= 2000; k++) begin
            tick(); samp();
            if (m0_err_o || m1_err_o) err_seen++;
            if (!s_cyc_o) cyc_low++;
        end
        check("stall_err", err_seen, 0);
        check("stall_cyc", cyc_low, 0);
        check("stall_gnt", gnt_o, 2'b01);
`endif
        tick(); m0_cyc = 0; m0_stb = 0; samp();
        tick(); samp();
        check("stall_rel", gnt_o, 2'b00);
        tick(); samp();
        check("stall_m1", gnt_o, 2'b10);
        tick(); m1_cyc = 0; m1_stb = 0;
        tick(); samp();
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
